// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared fetch/decode types and constants
package kamus_pkg;

    // addi x0,x0,0; also used by ID when inserting bubbles
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] next_pc;
    } fetch_entry_t;

endpackage

// File: rtl/kamus_fifo_mem.sv
// rtl/kamus_fifo_mem.sv - DEPTH x fetch_entry_t register array, one write port, one async read port
module kamus_fifo_mem
    import kamus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fetch_entry_t  wr_data,
    input  logic [AW-1:0] rd_addr,
    output fetch_entry_t  rd_data
);

    fetch_entry_t mem [DEPTH];

    // Contents are never reset; only entries covered by the occupancy count are observed.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/kamus_fetch_queue.sv
// rtl/kamus_fetch_queue.sv - IF-to-ID decoupling instruction queue with flush
module kamus_fetch_queue
    import kamus_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = kamus_pkg::NOP_INSTR
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    output logic                       if_ready_o,
    input  logic [31:0]                instr_data_i,
    input  logic [31:0]                next_pc_i,
    output logic                       id_valid_o,
    input  logic                       id_ready_i,
    output logic [31:0]                instr_data_o,
    output logic [31:0]                next_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    // Handshakes depend only on registered occupancy (plus flush), never on the other side.
    assign if_ready_o = (count_q != FULL_CNT) & ~flush_i;
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_valid_o & id_ready_i;

    assign wr_entry.instr   = instr_data_i;
    assign wr_entry.next_pc = next_pc_i;

    kamus_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk_i   (clk_i),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (head_entry)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign instr_data_o = id_valid_o ? head_entry.instr   : NOP_INSTR;
    assign next_pc_o    = id_valid_o ? head_entry.next_pc : 32'h0;
    assign count_o      = count_q;

endmodule
